// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - strobe-sampled push-button debouncer with press/release pulses
//
// Purpose:
//   Cleans up one raw, asynchronous push-button input. The button is
//   synchronized on every clock. It is only sampled on cycles where the
//   external clock-enable strobe is high. A new level is accepted after
//   STABLE_TICKS consecutive samples that differ from the current level.
//
// Parameters:
//   STABLE_TICKS  consecutive differing samples needed to flip the level
//                 (1 .. 2**CNT_WIDTH-1)
//   CNT_WIDTH     width of the stability counter
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   enable    in   sample strobe; every cycle with enable=1 is one sample
//   button    in   raw button, asynchronous to clock
//   level     out  debounced level
//   pressed   out  one-cycle pulse when level goes 0->1
//   released  out  one-cycle pulse when level goes 1->0

module button_debouncer #(
  parameter int STABLE_TICKS = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic button,
  output logic level,
  output logic pressed,
  output logic released
);

  // Counter value on the sample that completes a stable run.
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(STABLE_TICKS - 1);

  logic                 sync_meta;
  logic                 sync;
  logic [CNT_WIDTH-1:0] count;

  // Two-flop synchronizer, free-running regardless of the strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= button;
      sync      <= sync_meta;
    end
  end

  // level selects the LOW/HIGH side of the filter; a non-zero count means a
  // change is being qualified. Any agreeing sample abandons the wait, so a
  // bounce restarts the qualification from scratch.
  always_ff @(posedge clock) begin
    if (reset) begin
      level    <= 1'b0;
      count    <= '0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      pressed  <= 1'b0;
      released <= 1'b0;
      if (enable) begin
        if (sync == level) begin
          count <= '0;
        end else if (count == LAST_COUNT) begin
          level    <= ~level;
          count    <= '0;
          pressed  <= ~level;
          released <= level;
        end else begin
          count <= count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer

module tb_button_debouncer;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic button;
  logic level;
  logic pressed;
  logic released;

  int checks = 0;
  int errors = 0;
  int pressed_cnt = 0;
  int released_cnt = 0;
  int both_cnt = 0;

  button_debouncer #(
    .STABLE_TICKS(4),
    .CNT_WIDTH   (3)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .button  (button),
    .level   (level),
    .pressed (pressed),
    .released(released)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given strobe value; outputs sampled 1 time unit after the edge.
  task automatic step(input logic en);
    enable = en;
    @(posedge clock);
    #1;
    if (pressed === 1'b1) pressed_cnt++;
    if (released === 1'b1) released_cnt++;
    if (pressed === 1'b1 && released === 1'b1) both_cnt++;
  endtask

  // One strobe period: 7 idle clocks then the strobe clock.
  task automatic period();
    repeat (7) step(1'b0);
    step(1'b1);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    button = 1'b1;

    // Reset for 3 clocks with button high and strobe active.
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("reset_level", level, 1'b0);
      check("reset_pressed", pressed, 1'b0);
      check("reset_released", released, 1'b0);
    end
    reset = 1'b0;

    // Level rises only on the 4th strobe after reset.
    repeat (3) period();
    check("post_reset_s3_level", level, 1'b0);
    period();
    check("post_reset_s4_level", level, 1'b1);
    check("post_reset_pressed", pressed, 1'b1);
    step(1'b0);
    check("post_reset_pressed_width", pressed, 1'b0);
    check("post_reset_pressed_cnt", pressed_cnt, 1);

    // Release.
    button = 1'b0;
    repeat (3) period();
    check("release_s3_level", level, 1'b1);
    period();
    check("release_s4_level", level, 1'b0);
    check("release_pulse", released, 1'b1);
    check("release_no_pressed", pressed, 1'b0);
    step(1'b0);
    check("release_pulse_width", released, 1'b0);
    check("release_cnt", released_cnt, 1);

    // Clean press.
    button = 1'b1;
    repeat (3) period();
    check("press_s3_level", level, 1'b0);
    period();
    check("press_s4_level", level, 1'b1);
    check("press_pulse", pressed, 1'b1);
    check("press_no_released", released, 1'b0);
    step(1'b0);
    check("press_pulse_width", pressed, 1'b0);
    check("press_cnt", pressed_cnt, 2);

    // Back to low before the bounce test.
    button = 1'b0;
    repeat (4) period();
    check("low_again_level", level, 1'b0);
    check("low_again_rel_cnt", released_cnt, 2);

    // Bounce: high 3 strobes, low 1 strobe, then high again.
    button = 1'b1;
    repeat (3) period();
    check("bounce_s3_level", level, 1'b0);
    button = 1'b0;
    period();
    check("bounce_s4_level", level, 1'b0);
    button = 1'b1;
    repeat (3) period();
    check("bounce_final_s3_level", level, 1'b0);
    period();
    check("bounce_final_s4_level", level, 1'b1);
    check("bounce_pressed_cnt", pressed_cnt, 3);

    // Back to low before the reset-mid-wait test.
    button = 1'b0;
    repeat (4) period();
    check("low_third_level", level, 1'b0);

    // Reset mid-wait: count reaches 2, then a one-clock reset.
    button = 1'b1;
    repeat (2) period();
    check("midwait_level", level, 1'b0);
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    check("midwait_reset_level", level, 1'b0);
    repeat (2) period();
    check("midwait_s2_level", level, 1'b0);
    period();
    check("midwait_s3_level", level, 1'b0);
    check("midwait_no_early_press", pressed_cnt, 3);
    period();
    check("midwait_s4_level", level, 1'b1);
    check("midwait_pressed", pressed, 1'b1);
    check("midwait_pressed_cnt", pressed_cnt, 4);

    // Reset while level is high: level drops with no released pulse.
    reset = 1'b1;
    step(1'b0);
    check("reset_high_level", level, 1'b0);
    check("reset_high_released", released, 1'b0);
    button = 1'b0;
    step(1'b0);
    reset = 1'b0;
    repeat (2) period();
    check("reset_high_level_hold", level, 1'b0);
    check("reset_high_rel_cnt", released_cnt, 3);

    // Continuous enable: level rises 2+4 clocks after the button edge.
    button = 1'b1;
    repeat (5) step(1'b1);
    check("cont_clk5_level", level, 1'b0);
    step(1'b1);
    check("cont_clk6_level", level, 1'b1);
    check("cont_clk6_pressed", pressed, 1'b1);
    step(1'b1);
    check("cont_clk7_pressed", pressed, 1'b0);
    check("cont_pressed_cnt", pressed_cnt, 5);

    check("never_both_pulses", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
